srlatch_seq: RTL and testbench

SRLATCH_SEQ -- requirements
Module: srlatch_seq

---
 rtl/srlatch_seq.sv | 144 ++++++++++++++
 tb/tb_srlatch_seq.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/srlatch_seq.sv
`default_nettype none
// ============================================================================
//  Module      : srlatch_seq
//  Description : Two-requester sequencer for a bank of four S/R latches.
//                Arbitrates round-robin between requesters A and B, drives
//                a timed set/reset pulse, waits a guard interval, then reads
//                the latch back and reports completion and mismatches.
//  Revision    : 1.0 - initial release
// ============================================================================
module srlatch_seq #(
    parameter int PULSE_W = 2,
    parameter int GUARD_W = 1
) (
    input  logic       clk,
    input  logic       rst,        // asynchronous, active-low
    input  logic       a_valid,
    input  logic       a_op,
    input  logic [1:0] a_idx,
    output logic       a_ready,
    input  logic       b_valid,
    input  logic       b_op,
    input  logic [1:0] b_idx,
    output logic       b_ready,
    output logic [3:0] s,
    output logic [3:0] r,
    input  logic [3:0] q_fb,
    output logic       done,
    output logic       done_id,
    output logic       err,
    output logic [3:0] err_cnt,
    output logic       busy
);

    localparam logic [3:0] c_PULSE_LAST = 4'(PULSE_W - 1);
    localparam logic [3:0] c_GUARD_LAST = 4'(GUARD_W - 1);
    localparam logic [3:0] c_CNT_MAX    = 4'hF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GUARD = 2'd2,
        CHECK = 2'd3
    } state_t;

    state_t     r_state;
    logic       r_op;
    logic [1:0] r_idx;
    logic       r_id;
    logic       r_last_grant;   // 0 = A granted last, 1 = B granted last
    logic [3:0] r_cnt;
    logic [3:0] r_s;
    logic [3:0] r_r;
    logic [3:0] r_err_cnt;

    logic       w_idle;
    logic       w_grant_a;
    logic       w_grant_b;
    logic       w_sel_op;
    logic [1:0] w_sel_idx;
    logic [3:0] w_onehot;
    logic       w_mismatch;

    // Round-robin arbitration: on a tie the requester not served last wins
    always_comb begin
        w_idle    = (r_state == IDLE);
        w_grant_a = a_valid && (!b_valid || r_last_grant);
        w_grant_b = b_valid && (!a_valid || !r_last_grant);
        w_sel_op  = w_grant_a ? a_op  : b_op;
        w_sel_idx = w_grant_a ? a_idx : b_idx;
        w_onehot  = 4'b0001 << w_sel_idx;
    end

    assign a_ready = w_idle && w_grant_a;
    assign b_ready = w_idle && w_grant_b;

    // Completion status is decoded from the state register; q_fb is only
    // looked at while in CHECK.
    assign w_mismatch = (q_fb[r_idx] != r_op);
    assign done       = (r_state == CHECK);
    assign done_id    = done && r_id;
    assign err        = done && w_mismatch;
    assign busy       = (r_state != IDLE);
    assign s          = r_s;
    assign r          = r_r;
    assign err_cnt    = r_err_cnt;

    // Sequencer FSM: accept, pulse, guard, check
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_op         <= 1'b0;
            r_idx        <= 2'd0;
            r_id         <= 1'b0;
            r_last_grant <= 1'b1;
            r_cnt        <= 4'd0;
            r_s          <= 4'd0;
            r_r          <= 4'd0;
            r_err_cnt    <= 4'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (a_ready || b_ready) begin
                        r_op         <= w_sel_op;
                        r_idx        <= w_sel_idx;
                        r_id         <= b_ready;
                        r_last_grant <= b_ready;
                        r_cnt        <= c_PULSE_LAST;
                        r_s          <= w_sel_op ? w_onehot : 4'd0;
                        r_r          <= w_sel_op ? 4'd0 : w_onehot;
                        r_state      <= PULSE;
                    end
                end
                PULSE: begin
                    if (r_cnt == 4'd0) begin
                        r_s     <= 4'd0;
                        r_r     <= 4'd0;
                        r_cnt   <= c_GUARD_LAST;
                        r_state <= GUARD;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                GUARD: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= CHECK;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                CHECK: begin
                    if (w_mismatch && (r_err_cnt != c_CNT_MAX)) begin
                        r_err_cnt <= r_err_cnt + 4'd1;
                    end
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_srlatch_seq.sv
`timescale 1ns/1ps
module tb_srlatch_seq;

    localparam int PW [2] = '{2, 1};
    localparam int GW [2] = '{1, 3};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       a_valid [2];
    logic       a_op    [2];
    logic [1:0] a_idx   [2];
    logic       a_ready [2];
    logic       b_valid [2];
    logic       b_op    [2];
    logic [1:0] b_idx   [2];
    logic       b_ready [2];
    logic [3:0] s       [2];
    logic [3:0] r       [2];
    logic [3:0] q_fb    [2];
    logic       done    [2];
    logic       done_id [2];
    logic       err     [2];
    logic [3:0] err_cnt [2];
    logic       busy    [2];

    logic [3:0] q_model   [2] = '{4'h0, 4'h0};
    logic [3:0] stuck_en  [2] = '{4'h0, 4'h0};
    logic [3:0] stuck_val [2] = '{4'h0, 4'h0};
    logic [3:0] exp_cnt   [2] = '{4'h0, 4'h0};

    int cyc    = 0;
    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        int         t;
        logic       id;
        logic       op;
        logic [1:0] idx;
        logic       e;
    } exp_t;

    exp_t sb [2][$];

    srlatch_seq #(.PULSE_W(2), .GUARD_W(1)) dut0 (
        .clk(clk), .rst(rst),
        .a_valid(a_valid[0]), .a_op(a_op[0]), .a_idx(a_idx[0]), .a_ready(a_ready[0]),
        .b_valid(b_valid[0]), .b_op(b_op[0]), .b_idx(b_idx[0]), .b_ready(b_ready[0]),
        .s(s[0]), .r(r[0]), .q_fb(q_fb[0]),
        .done(done[0]), .done_id(done_id[0]), .err(err[0]), .err_cnt(err_cnt[0]), .busy(busy[0])
    );

    srlatch_seq #(.PULSE_W(1), .GUARD_W(3)) dut1 (
        .clk(clk), .rst(rst),
        .a_valid(a_valid[1]), .a_op(a_op[1]), .a_idx(a_idx[1]), .a_ready(a_ready[1]),
        .b_valid(b_valid[1]), .b_op(b_op[1]), .b_idx(b_idx[1]), .b_ready(b_ready[1]),
        .s(s[1]), .r(r[1]), .q_fb(q_fb[1]),
        .done(done[1]), .done_id(done_id[1]), .err(err[1]), .err_cnt(err_cnt[1]), .busy(busy[1])
    );

    // Latch bank model with optional stuck bits on the feedback path
    always_comb begin
        for (int d = 0; d < 2; d++)
            q_fb[d] = (q_model[d] & ~stuck_en[d]) | (stuck_val[d] & stuck_en[d]);
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int d = 0; d < 2; d++)
            q_model[d] <= (q_model[d] | s[d]) & ~r[d];
    end

    // Scoreboard monitor: pushes on acceptance, checks pulse shape and pops on done
    always @(negedge clk) begin : mon
        logic [3:0] es, er;
        int         dt;
        logic       has;
        exp_t       e;
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if ($countones({s[d], r[d]}) > 1) begin
                n_fail++;
                $display("FAIL mon_onehot dut%0d s=%b r=%b required at most one bit high", d, s[d], r[d]);
            end
            if (!rst) begin
                sb[d].delete();
                exp_cnt[d] = 4'd0;
                n_cmp++;
                if ({s[d], r[d], done[d], err[d], busy[d], err_cnt[d]} !== 15'd0) begin
                    n_fail++;
                    $display("FAIL mon_reset dut%0d s=%b r=%b done=%b err=%b busy=%b err_cnt=%0d required all 0",
                             d, s[d], r[d], done[d], err[d], busy[d], err_cnt[d]);
                end
            end else begin
                has = (sb[d].size() > 0);
                es  = 4'd0;
                er  = 4'd0;
                dt  = 0;
                if (has) begin
                    dt = cyc - sb[d][0].t;
                    if (dt >= 1 && dt <= PW[d]) begin
                        if (sb[d][0].op) es = 4'b0001 << sb[d][0].idx;
                        else             er = 4'b0001 << sb[d][0].idx;
                    end
                end
                n_cmp++;
                if (s[d] !== es || r[d] !== er) begin
                    n_fail++;
                    $display("FAIL mon_sr dut%0d cyc=%0d s=%b r=%b required s=%b r=%b", d, cyc, s[d], r[d], es, er);
                end
                n_cmp++;
                if (busy[d] !== has) begin
                    n_fail++;
                    $display("FAIL mon_busy dut%0d cyc=%0d busy=%b required %b", d, cyc, busy[d], has);
                end
                n_cmp++;
                if (err_cnt[d] !== exp_cnt[d]) begin
                    n_fail++;
                    $display("FAIL mon_err_cnt dut%0d err_cnt=%0d required %0d", d, err_cnt[d], exp_cnt[d]);
                end
                n_cmp++;
                if (has && (a_ready[d] || b_ready[d])) begin
                    n_fail++;
                    $display("FAIL mon_ready_busy dut%0d a_ready=%b b_ready=%b required 0 while busy", d, a_ready[d], b_ready[d]);
                end
                n_cmp++;
                if (a_ready[d] && b_ready[d]) begin
                    n_fail++;
                    $display("FAIL mon_two_ready dut%0d both ready high required at most one", d);
                end
                if (done[d]) begin
                    n_cmp++;
                    if (!has) begin
                        n_fail++;
                        $display("FAIL mon_spurious_done dut%0d done=1 required 0 (nothing in flight)", d);
                    end else begin
                        e = sb[d].pop_front();
                        if (dt != PW[d] + GW[d] + 1 || done_id[d] !== e.id || err[d] !== e.e) begin
                            n_fail++;
                            $display("FAIL mon_done dut%0d latency=%0d id=%b err=%b required latency=%0d id=%b err=%b",
                                     d, dt, done_id[d], err[d], PW[d] + GW[d] + 1, e.id, e.e);
                        end
                        if (e.e && exp_cnt[d] != 4'hF) exp_cnt[d] = exp_cnt[d] + 4'd1;
                    end
                end else begin
                    n_cmp++;
                    if (err[d] !== 1'b0 || (has && dt > PW[d] + GW[d] + 1)) begin
                        n_fail++;
                        $display("FAIL mon_no_done dut%0d err=%b dt=%0d required err=0 and done by %0d",
                                 d, err[d], dt, PW[d] + GW[d] + 1);
                        if (has && dt > PW[d] + GW[d] + 1) void'(sb[d].pop_front());
                    end
                end
                if (a_ready[d] && a_valid[d]) begin
                    e.t = cyc; e.id = 1'b0; e.op = a_op[d]; e.idx = a_idx[d];
                    e.e = stuck_en[d][a_idx[d]] && (stuck_val[d][a_idx[d]] != a_op[d]);
                    sb[d].push_back(e);
                end else if (b_ready[d] && b_valid[d]) begin
                    e.t = cyc; e.id = 1'b1; e.op = b_op[d]; e.idx = b_idx[d];
                    e.e = stuck_en[d][b_idx[d]] && (stuck_val[d][b_idx[d]] != b_op[d]);
                    sb[d].push_back(e);
                end
            end
        end
    end

    // Drive one command and hold it until accepted; scramble inputs afterwards
    task automatic issue(input int d, input logic who, input logic op, input logic [1:0] idx, output int t_acc);
        bit got = 0;
        t_acc = -1;
        if (!who) begin a_valid[d] = 1'b1; a_op[d] = op; a_idx[d] = idx; end
        else      begin b_valid[d] = 1'b1; b_op[d] = op; b_idx[d] = idx; end
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (who ? b_ready[d] : a_ready[d]) begin got = 1; t_acc = cyc; end
        end
        n_cmp++;
        if (!got) begin
            n_fail++;
            $display("FAIL issue_accept dut%0d accepted=0 required 1", d);
        end
        @(posedge clk); #1;
        a_valid[d] = 1'b0; b_valid[d] = 1'b0;
        a_op[d] = 1'($urandom); a_idx[d] = 2'($urandom);
        b_op[d] = 1'($urandom); b_idx[d] = 2'($urandom);
    endtask

    task automatic wait_done(input int d, output int t_done, output logic e, output logic id);
        bit got = 0;
        t_done = -1; e = 1'b0; id = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (done[d]) begin got = 1; t_done = cyc; e = err[d]; id = done_id[d]; end
        end
        n_cmp++;
        if (!got) begin
            n_fail++;
            $display("FAIL wait_done dut%0d done seen=0 required 1", d);
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if ({s[d], r[d], done[d], err[d], busy[d], err_cnt[d]} !== 15'd0) begin
                n_fail++;
                $display("FAIL test_reset dut%0d s=%b r=%b done=%b err=%b busy=%b err_cnt=%0d required all 0",
                         d, s[d], r[d], done[d], err[d], busy[d], err_cnt[d]);
            end
        end
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_single_set();
        int t, td; logic e, id;
        issue(0, 1'b0, 1'b1, 2'd2, t);
        n_cmp++;
        if (s[0] !== 4'b0100) begin
            n_fail++;
            $display("FAIL single_set_s s=%b required 0100", s[0]);
        end
        wait_done(0, td, e, id);
        n_cmp++;
        if (td - t != 4 || id !== 1'b0 || e !== 1'b0 || q_model[0][2] !== 1'b1) begin
            n_fail++;
            $display("FAIL single_set latency=%0d id=%b err=%b q2=%b required 4 0 0 1", td - t, id, e, q_model[0][2]);
        end
    endtask

    task automatic test_contention();
        int  t_prev = -100;
        bit  got;
        do_reset();
        a_valid[0] = 1'b1; a_op[0] = 1'b1; a_idx[0] = 2'd0;
        b_valid[0] = 1'b1; b_op[0] = 1'b1; b_idx[0] = 2'd3;
        for (int k = 0; k < 3; k++) begin
            got = 0;
            for (int i = 0; i < 40 && !got; i++) begin
                @(negedge clk);
                if (a_ready[0] || b_ready[0]) got = 1;
            end
            n_cmp++;
            if (!got || b_ready[0] !== 1'(k % 2) || (k > 0 && cyc - t_prev < 5)) begin
                n_fail++;
                $display("FAIL contention grant%0d got=%0d b_won=%b spacing=%0d required b_won=%0d spacing>=5",
                         k, got, b_ready[0], cyc - t_prev, k % 2);
            end
            t_prev = cyc;
            @(posedge clk); #1;
        end
        a_valid[0] = 1'b0; b_valid[0] = 1'b0;
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic test_mismatch();
        int t, td; logic e, id;
        stuck_en[0] = 4'b0010; stuck_val[0] = 4'b0010;
        issue(0, 1'b1, 1'b0, 2'd1, t);
        n_cmp++;
        if (r[0] !== 4'b0010 || s[0] !== 4'b0000) begin
            n_fail++;
            $display("FAIL mismatch_r r=%b s=%b required r=0010 s=0000", r[0], s[0]);
        end
        wait_done(0, td, e, id);
        n_cmp++;
        if (id !== 1'b1 || e !== 1'b1 || err_cnt[0] !== 4'd1) begin
            n_fail++;
            $display("FAIL mismatch_first id=%b err=%b err_cnt=%0d required 1 1 1", id, e, err_cnt[0]);
        end
        for (int k = 0; k < 19; k++) begin
            issue(0, 1'b1, 1'b0, 2'd1, t);
            wait_done(0, td, e, id);
        end
        n_cmp++;
        if (err_cnt[0] !== 4'd15) begin
            n_fail++;
            $display("FAIL mismatch_saturate err_cnt=%0d required 15", err_cnt[0]);
        end
        stuck_en[0] = 4'b0000; stuck_val[0] = 4'b0000;
    endtask

    task automatic test_reset_mid_pulse();
        int t, td; logic e, id;
        issue(0, 1'b0, 1'b1, 2'd0, t);
        @(posedge clk); #2;
        n_cmp++;
        if (s[0] !== 4'b0001) begin
            n_fail++;
            $display("FAIL midreset_pre s=%b required 0001", s[0]);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (s[0] !== 4'd0 || r[0] !== 4'd0 || busy[0] !== 1'b0 || done[0] !== 1'b0 || err_cnt[0] !== 4'd0) begin
            n_fail++;
            $display("FAIL midreset_async s=%b r=%b busy=%b done=%b err_cnt=%0d required all 0",
                     s[0], r[0], busy[0], done[0], err_cnt[0]);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        issue(0, 1'b0, 1'b0, 2'd0, t);
        wait_done(0, td, e, id);
        n_cmp++;
        if (td - t != 4 || e !== 1'b0 || id !== 1'b0 || q_model[0][0] !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_after latency=%0d err=%b id=%b q0=%b required 4 0 0 0", td - t, e, id, q_model[0][0]);
        end
    endtask

    task automatic test_sweep();
        int t, td; logic e, id;
        issue(1, 1'b0, 1'b1, 2'd3, t);
        wait_done(1, td, e, id);
        n_cmp++;
        if (td - t != 5 || e !== 1'b0 || id !== 1'b0) begin
            n_fail++;
            $display("FAIL sweep_set latency=%0d err=%b id=%b required 5 0 0", td - t, e, id);
        end
        issue(1, 1'b1, 1'b0, 2'd3, t);
        wait_done(1, td, e, id);
        n_cmp++;
        if (td - t != 5 || e !== 1'b0 || id !== 1'b1 || q_model[1][3] !== 1'b0) begin
            n_fail++;
            $display("FAIL sweep_reset latency=%0d err=%b id=%b q3=%b required 5 0 1 0", td - t, e, id, q_model[1][3]);
        end
    endtask

    initial begin
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            a_valid[d] = 1'b0; a_op[d] = 1'b0; a_idx[d] = 2'd0;
            b_valid[d] = 1'b0; b_op[d] = 1'b0; b_idx[d] = 2'd0;
        end
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_single_set();
        test_contention();
        test_mismatch();
        test_reset_mid_pulse();
        test_sweep();
        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
